// File: rtl/tt_sweep_pkg.sv
// Shared FSM encoding and sizing constants for truth_table_sweeper.
package tt_sweep_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DRIVE  = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } state_t;

    localparam int SETTLE_W = 8;
    localparam int N_MAX    = 16;
    localparam int M_MAX    = 32;

endpackage

// File: rtl/tt_vector_counter.sv
// N-bit sweep vector register with clear, saturating increment and last-vector flag.
module tt_vector_counter #(
    parameter int N = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr,
    input  logic         inc,
    output logic [N-1:0] vec,
    output logic         last
);

    assign last = &vec;

    // Holds at all-ones rather than wrapping back to zero.
    always_ff @(posedge clk) begin
        if (reset) begin
            vec <= '0;
        end else if (clr) begin
            vec <= '0;
        end else if (inc && !last) begin
            vec <= vec + N'(1);
        end
    end

endmodule

// File: rtl/truth_table_sweeper.sv
// Exhaustive equivalence checker sweeping all 2^N input vectors across two functions.
// Optional: define TRUTH_TABLE_SWEEPER_STOP_ON_FIRST_EN to end the sweep at the first mismatch.
module truth_table_sweeper
    import tt_sweep_pkg::*;
#(
    parameter int N      = 2,
    parameter int M      = 1,
    parameter int SETTLE = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    output logic [N-1:0] vec_out,
    input  logic [M-1:0] fa_in,
    input  logic [M-1:0] fb_in,
    output logic         busy,
    output logic         done,
    output logic         equal,
    output logic [N:0]   mismatch_count,
    output logic [N-1:0] first_mismatch_vec,
    output logic         first_valid
);

    state_t              state, state_nxt;
    logic [SETTLE_W-1:0] settle_cnt;
    logic                vec_clr, vec_inc, vec_last;
    logic                load_settle;
    logic                hit;
    logic [N:0]          count_nxt;

    tt_vector_counter #(.N(N)) u_vec (
        .clk   (clk),
        .reset (reset),
        .clr   (vec_clr),
        .inc   (vec_inc),
        .vec   (vec_out),
        .last  (vec_last)
    );

    assign hit       = (state == SAMPLE) && (fa_in != fb_in);
    assign count_nxt = mismatch_count + {{N{1'b0}}, hit};
    assign busy      = (state == DRIVE) || (state == SAMPLE);
    assign done      = (state == DONE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        vec_clr     = 1'b0;
        vec_inc     = 1'b0;
        load_settle = 1'b0;
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    vec_clr     = 1'b1;
                    load_settle = 1'b1;
                    state_nxt   = (SETTLE == 0) ? SAMPLE : DRIVE;
                end
            end
            DRIVE: begin
                if (settle_cnt <= SETTLE_W'(1)) begin
                    state_nxt = SAMPLE;
                end
            end
            SAMPLE: begin
`ifdef TRUTH_TABLE_SWEEPER_STOP_ON_FIRST_EN
                if (hit || vec_last) begin
`else
                if (vec_last) begin
`endif
                    state_nxt = DONE;
                end else begin
                    vec_inc     = 1'b1;
                    load_settle = 1'b1;
                    state_nxt   = (SETTLE == 0) ? SAMPLE : DRIVE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Result registers; equal is resolved on the final SAMPLE so it includes that vector.
    always_ff @(posedge clk) begin
        if (reset) begin
            settle_cnt         <= '0;
            mismatch_count     <= '0;
            first_mismatch_vec <= '0;
            first_valid        <= 1'b0;
            equal              <= 1'b0;
        end else begin
            if (load_settle) begin
                settle_cnt <= SETTLE_W'(SETTLE);
            end else if (state == DRIVE) begin
                settle_cnt <= settle_cnt - SETTLE_W'(1);
            end

            if (vec_clr) begin
                mismatch_count     <= '0;
                first_mismatch_vec <= '0;
                first_valid        <= 1'b0;
                equal              <= 1'b0;
            end else if (hit) begin
                mismatch_count <= count_nxt;
                if (!first_valid) begin
                    first_mismatch_vec <= vec_out;
                    first_valid        <= 1'b1;
                end
            end

            if (state == SAMPLE && state_nxt == DONE) begin
                equal <= (count_nxt == '0);
            end
        end
    end

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Randomized self-checking bench: two sweeper instances (N=2/SETTLE=1 and N=4/SETTLE=0)
// driven from random truth tables and compared against a truth-table reference model.
module tb_truth_table_sweeper;

    localparam int N0 = 2, M0 = 1, S0 = 1;
    localparam int N1 = 4, M1 = 2, S1 = 0;

    logic clk = 1'b0;
    logic reset;
    logic start_s [2];
    logic [31:0] tbl_a [2][16];
    logic [31:0] tbl_b [2][16];

    always #5 clk = ~clk;

    logic [N0-1:0] vec0, fvec0;
    logic [M0-1:0] fa0, fb0;
    logic [N0:0]   mc0;
    logic          busy0, done0, equal0, fv0;

    logic [N1-1:0] vec1, fvec1;
    logic [M1-1:0] fa1, fb1;
    logic [N1:0]   mc1;
    logic          busy1, done1, equal1, fv1;

    assign fa0 = tbl_a[0][4'(vec0)][M0-1:0];
    assign fb0 = tbl_b[0][4'(vec0)][M0-1:0];
    assign fa1 = tbl_a[1][vec1][M1-1:0];
    assign fb1 = tbl_b[1][vec1][M1-1:0];

    truth_table_sweeper #(.N(N0), .M(M0), .SETTLE(S0)) u_dut0 (
        .clk(clk), .reset(reset), .start(start_s[0]), .vec_out(vec0),
        .fa_in(fa0), .fb_in(fb0), .busy(busy0), .done(done0), .equal(equal0),
        .mismatch_count(mc0), .first_mismatch_vec(fvec0), .first_valid(fv0)
    );

    truth_table_sweeper #(.N(N1), .M(M1), .SETTLE(S1)) u_dut1 (
        .clk(clk), .reset(reset), .start(start_s[1]), .vec_out(vec1),
        .fa_in(fa1), .fb_in(fb1), .busy(busy1), .done(done1), .equal(equal1),
        .mismatch_count(mc1), .first_mismatch_vec(fvec1), .first_valid(fv1)
    );

    int   vec_v [2], cnt_v [2], fvec_v [2];
    logic busy_v [2], done_v [2], equal_v [2], fv_v [2];

    always_comb begin
        vec_v[0]  = int'(vec0);  vec_v[1]  = int'(vec1);
        cnt_v[0]  = int'(mc0);   cnt_v[1]  = int'(mc1);
        fvec_v[0] = int'(fvec0); fvec_v[1] = int'(fvec1);
        busy_v[0] = busy0;       busy_v[1] = busy1;
        done_v[0] = done0;       done_v[1] = done1;
        equal_v[0] = equal0;     equal_v[1] = equal1;
        fv_v[0]   = fv0;         fv_v[1]   = fv1;
    end

    int errs = 0;
    int checks = 0;

    task automatic chk_eq(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    function automatic int n_of(input int id);
        return (id == 0) ? N0 : N1;
    endfunction

    function automatic int m_of(input int id);
        return (id == 0) ? M0 : M1;
    endfunction

    function automatic int s_of(input int id);
        return (id == 0) ? S0 : S1;
    endfunction

    task automatic check_cleared(input int id, input string ctx);
        chk_eq({ctx, ".vec"},   vec_v[id], 0);
        chk_eq({ctx, ".busy"},  int'(busy_v[id]), 0);
        chk_eq({ctx, ".done"},  int'(done_v[id]), 0);
        chk_eq({ctx, ".equal"}, int'(equal_v[id]), 0);
        chk_eq({ctx, ".count"}, cnt_v[id], 0);
        chk_eq({ctx, ".fv"},    int'(fv_v[id]), 0);
        chk_eq({ctx, ".fvec"},  fvec_v[id], 0);
    endtask

    // mode: 0 random, 1 identical, 2 all-inverted, 3 single flipped entry, 4 tables preset
    task automatic fill_tables(input int id, input int mode);
        int len, k;
        len = 1 << n_of(id);
        if (mode == 4) return;
        for (int v = 0; v < len; v++) begin
            tbl_a[id][v] = $urandom;
            case (mode)
                0:       tbl_b[id][v] = ($urandom_range(0, 2) == 0) ? $urandom : tbl_a[id][v];
                2:       tbl_b[id][v] = ~tbl_a[id][v];
                default: tbl_b[id][v] = tbl_a[id][v];
            endcase
        end
        if (mode == 3) begin
            k = $urandom_range(0, len - 1);
            tbl_b[id][k] = tbl_b[id][k] ^ (32'd1 << $urandom_range(0, m_of(id) - 1));
        end
    endtask

    task automatic run_sweep(input int id, input int mode, input bit mid_start, input string tag);
        int len, mask, exp_cnt, exp_first, exp_vec, exp_lat, visited, c, limit;
        bit pulsed;
        fill_tables(id, mode);
        len  = 1 << n_of(id);
        mask = (m_of(id) == 32) ? -1 : ((1 << m_of(id)) - 1);

        exp_cnt = 0; exp_first = -1; visited = len;
        for (int v = 0; v < len; v++) begin
            if ((tbl_a[id][v] & mask) != (tbl_b[id][v] & mask)) begin
                exp_cnt++;
                if (exp_first < 0) exp_first = v;
`ifdef TRUTH_TABLE_SWEEPER_STOP_ON_FIRST_EN
                visited = v + 1;
                break;
`endif
            end
        end
        exp_vec = visited - 1;
        exp_lat = visited * (s_of(id) + 1);

        @(negedge clk);
        start_s[id] = 1'b1;
        @(negedge clk);
        start_s[id] = 1'b0;
        chk_eq({tag, ".busy_after_start"}, int'(busy_v[id]), 1);
        chk_eq({tag, ".done_after_start"}, int'(done_v[id]), 0);

        c = 0; limit = exp_lat + 8; pulsed = 1'b0;
        while (!done_v[id] && c < limit) begin
            if (mid_start && !pulsed && busy_v[id] && vec_v[id] == 1) begin
                start_s[id] = 1'b1;
                pulsed = 1'b1;
            end
            @(negedge clk);
            c++;
            start_s[id] = 1'b0;
        end

        chk_eq({tag, ".latency"}, c, exp_lat);
        chk_eq({tag, ".done"},    int'(done_v[id]), 1);
        chk_eq({tag, ".busy"},    int'(busy_v[id]), 0);
        chk_eq({tag, ".equal"},   int'(equal_v[id]), (exp_cnt == 0) ? 1 : 0);
        chk_eq({tag, ".count"},   cnt_v[id], exp_cnt);
        chk_eq({tag, ".fv"},      int'(fv_v[id]), (exp_first >= 0) ? 1 : 0);
        chk_eq({tag, ".fvec"},    fvec_v[id], (exp_first >= 0) ? exp_first : 0);
        chk_eq({tag, ".vec"},     vec_v[id], exp_vec);
        @(negedge clk);
        chk_eq({tag, ".hold_done"},  int'(done_v[id]), 1);
        chk_eq({tag, ".hold_count"}, cnt_v[id], exp_cnt);
    endtask

    task automatic reset_mid(input int id, input string tag);
        int c;
        fill_tables(id, 1);
        @(negedge clk);
        start_s[id] = 1'b1;
        @(negedge clk);
        start_s[id] = 1'b0;
        c = 0;
        while (vec_v[id] != 2 && c < 64) begin
            @(negedge clk);
            c++;
        end
        chk_eq({tag, ".reached_vec2"}, vec_v[id], 2);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check_cleared(id, tag);
        run_sweep(id, 0, 1'b0, {tag, ".after"});
    endtask

    initial begin
        reset = 1'b1;
        start_s[0] = 1'b0;
        start_s[1] = 1'b0;
        for (int i = 0; i < 16; i++) begin
            tbl_a[0][i] = '0; tbl_b[0][i] = '0;
            tbl_a[1][i] = '0; tbl_b[1][i] = '0;
        end
        repeat (3) @(negedge clk);
        check_cleared(0, "rst0");
        check_cleared(1, "rst1");
        reset = 1'b0;

        // vec = {x,y}: fa = x&y, fb = ~(~x|~y)
        for (int v = 0; v < 4; v++) begin
            tbl_a[0][v] = 32'(v == 3);
            tbl_b[0][v] = 32'(v == 3);
        end
        run_sweep(0, 4, 1'b0, "and_eq");

        // fb = y|~x differs from x&y at 00 and 01
        for (int v = 0; v < 4; v++) begin
            tbl_b[0][v] = 32'((v & 1) | (((v >> 1) & 1) ^ 1));
        end
        run_sweep(0, 4, 1'b0, "and_vs_or");

        run_sweep(1, 2, 1'b0, "inv_n4");
        run_sweep(1, 1, 1'b0, "eq_n4");
        run_sweep(0, 3, 1'b1, "midstart0");
        run_sweep(1, 3, 1'b1, "midstart1");
        reset_mid(0, "rstmid0");
        reset_mid(1, "rstmid1");

        for (int i = 0; i < 24; i++) begin
            run_sweep(i % 2, $urandom_range(0, 3), 1'(i % 3 == 0), $sformatf("rnd%0d", i));
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
